udp_tx_buffered: RTL and testbench

UDP_TX_BUFFERED -- requirements
Module: udp_tx_buffered

---
 rtl/udp_pkg.sv | 35 +++
 rtl/udp_tx_buf.sv | 35 +++
 rtl/udp_tx_buffered.sv | 262 ++++++++++++++++++++++++++
 tb/tb_udp_tx_buffered.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// Shared definitions for the buffered UDP transmitter: FSM encoding,
// protocol constants and one's-complement checksum helpers.
package udp_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        FOLD      = 3'd2,
        WAIT_IP   = 3'd3,
        SEND_HDR  = 3'd4,
        SEND_DATA = 3'd5
    } udp_state_e;

    localparam int         UDP_HDR_LEN  = 8;
    localparam logic [7:0] IP_PROTO_UDP = 8'h11;

    // One end-around-carry step of the 32-bit accumulator.
    function automatic logic [31:0] csum_fold(input logic [31:0] acc);
        return {16'h0000, acc[31:16]} + {16'h0000, acc[15:0]};
    endfunction

    // Final UDP checksum: a zero complement is transmitted as all ones.
    function automatic logic [15:0] csum_final(input logic [15:0] sum, input logic en);
        logic [15:0] inv;
        inv = ~sum;
        if (!en) begin
            return 16'h0000;
        end else if (inv == 16'h0000) begin
            return 16'hFFFF;
        end else begin
            return inv;
        end
    endfunction

endpackage

// File: rtl/udp_tx_buf.sv
// Payload buffer: simple dual-port byte RAM with a registered
// (one-cycle latency) read port.
module udp_tx_buf #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          udp_send_clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_r [0:DEPTH-1];
    logic [7:0] rd_data_r;

    // Write port.
    always_ff @(posedge udp_send_clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge udp_send_clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/udp_tx_buffered.sv
// UDP transmitter: buffers a payload while summing it into the checksum,
// then streams the 8-byte UDP header followed by the payload to the IP layer.
module udp_tx_buffered
    import udp_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT_NUM = 16'hF000,
    parameter int          BUF_DEPTH      = 2048,
    parameter int          CSUM_EN        = 1
) (
    input  logic        udp_send_clk,
    input  logic        rstn,
    input  logic        app_data_request,
    input  logic [15:0] app_data_length,
    input  logic [15:0] udp_dest_port,
    input  logic [31:0] src_ip_addr,
    input  logic [31:0] dst_ip_addr,
    input  logic        app_data_in_valid,
    input  logic [7:0]  app_data_in,
    output logic        udp_send_ready,
    output logic        udp_send_ack,
    output logic        udp_len_err,
    input  logic        ip_send_ready,
    input  logic        ip_send_ack,
    output logic        udp_send_request,
    output logic        udp_data_out_valid,
    output logic [7:0]  udp_data_out,
    output logic [15:0] udp_packet_length
);

    localparam int          AW      = $clog2(BUF_DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(BUF_DEPTH);
    localparam logic        CSUM_ON = (CSUM_EN != 0);

    udp_state_e  state_r, state_next_s;
    logic [15:0] len_r, dport_r, pkt_len_r, csum_r;
    logic [15:0] wr_cnt_r, rd_cnt_r;
    logic [31:0] acc_r;
    logic [2:0]  hdr_idx_r;
    logic        fold_cnt_r;
    logic        ack_r, len_err_r, req_r, ready_r;
    logic        out_valid_r;
    logic [7:0]  out_data_r;

    logic        out_valid_next_s;
    logic [7:0]  out_data_next_s;
    logic [31:0] len_ext_s, preload_s, acc_add_s, acc_folded_s;
    logic        len_ok_s, wr_en_s, rd_en_s, last_wr_s, last_rd_s;
    logic [15:0] len_m1_s, rd_cnt_inc_s;
    logic [AW-1:0] rd_addr_s;
    logic [7:0]  rd_data_s, hdr_byte_s;
    logic [2:0]  hdr_sel_s;
    logic        unused_s;

    assign len_ext_s = {16'h0000, app_data_length};
    assign len_ok_s  = (len_ext_s != 32'd0) && (len_ext_s <= DEPTH_W);

    // Pseudo-header (addresses, protocol, length) plus the UDP header fields;
    // the UDP length field is counted twice, once in each header.
    assign preload_s = {16'h0000, src_ip_addr[31:16]} + {16'h0000, src_ip_addr[15:0]}
                     + {16'h0000, dst_ip_addr[31:16]} + {16'h0000, dst_ip_addr[15:0]}
                     + {24'h000000, IP_PROTO_UDP}
                     + ((len_ext_s + 32'(UDP_HDR_LEN)) << 1'b1)
                     + {16'h0000, LOCAL_PORT_NUM} + {16'h0000, udp_dest_port};

    assign acc_add_s    = wr_cnt_r[0] ? {24'h000000, app_data_in} : {16'h0000, app_data_in, 8'h00};
    assign acc_folded_s = csum_fold(csum_fold(acc_r));

    assign len_m1_s     = len_r - 16'd1;
    assign wr_en_s      = (state_r == LOAD) && app_data_in_valid;
    assign last_wr_s    = (wr_cnt_r == len_m1_s);
    assign last_rd_s    = (rd_cnt_r == len_m1_s);

    // Read runs one byte ahead of the output register; address 0 is primed during the header.
    assign rd_cnt_inc_s = rd_cnt_r + 16'd1;
    assign rd_en_s      = (state_r == SEND_HDR) || (state_r == SEND_DATA);
    assign rd_addr_s    = (state_r == SEND_HDR) ? {AW{1'b0}} : rd_cnt_inc_s[AW-1:0];
    assign hdr_sel_s    = (state_r == SEND_HDR) ? hdr_idx_r : 3'd0;
    assign unused_s     = ^{ip_send_ack, rd_cnt_inc_s};

    udp_tx_buf #(
        .DEPTH (BUF_DEPTH),
        .AW    (AW)
    ) u_buf (
        .udp_send_clk (udp_send_clk),
        .wr_en        (wr_en_s),
        .wr_addr      (wr_cnt_r[AW-1:0]),
        .wr_data      (app_data_in),
        .rd_en        (rd_en_s),
        .rd_addr      (rd_addr_s),
        .rd_data      (rd_data_s)
    );

    // Header byte selection, most significant byte of each field first.
    always_comb begin
        hdr_byte_s = 8'h00;
        case (hdr_sel_s)
            3'd0:    hdr_byte_s = LOCAL_PORT_NUM[15:8];
            3'd1:    hdr_byte_s = LOCAL_PORT_NUM[7:0];
            3'd2:    hdr_byte_s = dport_r[15:8];
            3'd3:    hdr_byte_s = dport_r[7:0];
            3'd4:    hdr_byte_s = pkt_len_r[15:8];
            3'd5:    hdr_byte_s = pkt_len_r[7:0];
            3'd6:    hdr_byte_s = csum_r[15:8];
            default: hdr_byte_s = csum_r[7:0];
        endcase
    end

    // Next-state and next output byte.
    always_comb begin
        state_next_s     = state_r;
        out_valid_next_s = 1'b0;
        out_data_next_s  = 8'h00;
        case (state_r)
            IDLE: begin
                if (app_data_request && len_ok_s) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (wr_en_s && last_wr_s) begin
                    state_next_s = FOLD;
                end else begin
                    state_next_s = LOAD;
                end
            end
            FOLD: begin
                if (fold_cnt_r) begin
                    state_next_s = WAIT_IP;
                end else begin
                    state_next_s = FOLD;
                end
            end
            WAIT_IP: begin
                if (ip_send_ready) begin
                    state_next_s     = SEND_HDR;
                    out_valid_next_s = 1'b1;
                    out_data_next_s  = hdr_byte_s;
                end else begin
                    state_next_s = WAIT_IP;
                end
            end
            SEND_HDR: begin
                out_valid_next_s = 1'b1;
                out_data_next_s  = hdr_byte_s;
                if (hdr_idx_r == 3'd7) begin
                    state_next_s = SEND_DATA;
                end else begin
                    state_next_s = SEND_HDR;
                end
            end
            SEND_DATA: begin
                out_valid_next_s = 1'b1;
                out_data_next_s  = rd_data_s;
                if (last_rd_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SEND_DATA;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register and registered handshake/stream outputs.
    always_ff @(posedge udp_send_clk) begin
        if (!rstn) begin
            state_r     <= IDLE;
            ready_r     <= 1'b1;
            req_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
        end else begin
            state_r     <= state_next_s;
            ready_r     <= (state_next_s == IDLE);
            req_r       <= (state_next_s == WAIT_IP);
            out_valid_r <= out_valid_next_s;
            out_data_r  <= out_data_next_s;
        end
    end

    // Request latching, payload counters and checksum datapath.
    always_ff @(posedge udp_send_clk) begin
        if (!rstn) begin
            len_r      <= 16'h0000;
            dport_r    <= 16'h0000;
            pkt_len_r  <= 16'(UDP_HDR_LEN);
            acc_r      <= 32'h0000_0000;
            csum_r     <= 16'h0000;
            wr_cnt_r   <= 16'h0000;
            rd_cnt_r   <= 16'h0000;
            hdr_idx_r  <= 3'd0;
            fold_cnt_r <= 1'b0;
            ack_r      <= 1'b0;
            len_err_r  <= 1'b0;
        end else begin
            ack_r     <= 1'b0;
            len_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (app_data_request && len_ok_s) begin
                        len_r     <= app_data_length;
                        dport_r   <= udp_dest_port;
                        pkt_len_r <= app_data_length + 16'(UDP_HDR_LEN);
                        acc_r     <= preload_s;
                        wr_cnt_r  <= 16'h0000;
                        rd_cnt_r  <= 16'h0000;
                        ack_r     <= 1'b1;
                    end else if (app_data_request) begin
                        len_err_r <= 1'b1;
                    end else begin
                        len_err_r <= 1'b0;
                    end
                end
                LOAD: begin
                    if (wr_en_s) begin
                        wr_cnt_r <= wr_cnt_r + 16'd1;
                        acc_r    <= acc_r + acc_add_s;
                    end else begin
                        wr_cnt_r <= wr_cnt_r;
                    end
                end
                FOLD: begin
                    fold_cnt_r <= ~fold_cnt_r;
                    if (!fold_cnt_r) begin
                        acc_r <= acc_folded_s;
                    end else begin
                        csum_r <= csum_final(acc_r[15:0], CSUM_ON);
                    end
                end
                WAIT_IP: begin
                    if (ip_send_ready) begin
                        hdr_idx_r <= 3'd1;
                    end else begin
                        hdr_idx_r <= 3'd0;
                    end
                end
                SEND_HDR: begin
                    hdr_idx_r <= hdr_idx_r + 3'd1;
                end
                SEND_DATA: begin
                    rd_cnt_r <= rd_cnt_r + 16'd1;
                end
                default: begin
                    hdr_idx_r <= 3'd0;
                end
            endcase
        end
    end

    assign udp_send_ready     = ready_r;
    assign udp_send_ack       = ack_r;
    assign udp_len_err        = len_err_r;
    assign udp_send_request   = req_r;
    assign udp_data_out_valid = out_valid_r;
    assign udp_data_out       = out_data_r;
    assign udp_packet_length  = pkt_len_r;

endmodule

// File: tb/tb_udp_tx_buffered.sv
// Directed bench for udp_tx_buffered: a checksum-enabled instance driven from a
// vector table plus hand-written reset/corner sequences, and a checksum-disabled
// instance sending a full buffer.
module tb_udp_tx_buffered;

    typedef struct {
        logic [15:0] len;
        logic [15:0] dport;
        logic [7:0]  p0;
        int          rdy_delay;
        logic        exp_err;
        logic [15:0] exp_pkt_len;
        logic [15:0] exp_csum;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, req1, req2, din_valid, ip_rdy, ip_ack;
    logic [15:0] len, dport;
    logic [31:0] sip, dip;
    logic [7:0]  din;

    logic        rdy1, ack1, err1, sreq1, ov1;
    logic [7:0]  od1;
    logic [15:0] pl1;
    logic        rdy2, ack2, err2, sreq2, ov2;
    logic [7:0]  od2;
    logic [15:0] pl2;

    int sel;
    int n_vec;
    int n_err;
    vec_t vecs[6];
    vec_t v2;

    logic        o_rdy, o_ack, o_err, o_sreq, o_valid;
    logic [7:0]  o_data;
    logic [15:0] o_pl;

    assign o_rdy   = (sel == 2) ? rdy2  : rdy1;
    assign o_ack   = (sel == 2) ? ack2  : ack1;
    assign o_err   = (sel == 2) ? err2  : err1;
    assign o_sreq  = (sel == 2) ? sreq2 : sreq1;
    assign o_valid = (sel == 2) ? ov2   : ov1;
    assign o_data  = (sel == 2) ? od2   : od1;
    assign o_pl    = (sel == 2) ? pl2   : pl1;

    udp_tx_buffered #(.LOCAL_PORT_NUM(16'hF000), .BUF_DEPTH(2048), .CSUM_EN(1)) dut1 (
        .udp_send_clk(clk), .rstn(rstn), .app_data_request(req1),
        .app_data_length(len), .udp_dest_port(dport), .src_ip_addr(sip), .dst_ip_addr(dip),
        .app_data_in_valid(din_valid), .app_data_in(din),
        .udp_send_ready(rdy1), .udp_send_ack(ack1), .udp_len_err(err1),
        .ip_send_ready(ip_rdy), .ip_send_ack(ip_ack), .udp_send_request(sreq1),
        .udp_data_out_valid(ov1), .udp_data_out(od1), .udp_packet_length(pl1)
    );

    udp_tx_buffered #(.LOCAL_PORT_NUM(16'hF000), .BUF_DEPTH(64), .CSUM_EN(0)) dut2 (
        .udp_send_clk(clk), .rstn(rstn), .app_data_request(req2),
        .app_data_length(len), .udp_dest_port(dport), .src_ip_addr(sip), .dst_ip_addr(dip),
        .app_data_in_valid(din_valid), .app_data_in(din),
        .udp_send_ready(rdy2), .udp_send_ack(ack2), .udp_len_err(err2),
        .ip_send_ready(ip_rdy), .ip_send_ack(ip_ack), .udp_send_request(sreq2),
        .udp_data_out_valid(ov2), .udp_data_out(od2), .udp_packet_length(pl2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] l, input logic [15:0] dp, input logic [7:0] p,
                                input int dly, input logic e, input logic [15:0] pl,
                                input logic [15:0] cs);
        vec_t v;
        v.len = l; v.dport = dp; v.p0 = p; v.rdy_delay = dly;
        v.exp_err = e; v.exp_pkt_len = pl; v.exp_csum = cs;
        return v;
    endfunction

    function automatic logic [7:0] exp_byte(input vec_t v, input int k);
        case (k)
            0:       return 8'hF0;
            1:       return 8'h00;
            2:       return v.dport[15:8];
            3:       return v.dport[7:0];
            4:       return v.exp_pkt_len[15:8];
            5:       return v.exp_pkt_len[7:0];
            6:       return v.exp_csum[15:8];
            7:       return v.exp_csum[7:0];
            default: return v.p0 + 8'(k - 8);
        endcase
    endfunction

    task automatic check_reset_state(input int d);
        sel = d;
        #1;
        chk("rst_ready",   32'(o_rdy),   32'd1);
        chk("rst_ack",     32'(o_ack),   32'd0);
        chk("rst_len_err", 32'(o_err),   32'd0);
        chk("rst_request", 32'(o_sreq),  32'd0);
        chk("rst_valid",   32'(o_valid), 32'd0);
        chk("rst_data",    32'(o_data),  32'd0);
        chk("rst_pkt_len", 32'(o_pl),    32'h0008);
    endtask

    task automatic feed_payload(input logic [15:0] n, input logic [7:0] p0, input logic gap);
        for (int i = 0; i < int'(n); i++) begin
            if (gap && i == 1) begin
                din_valid = 1'b0;
                din = 8'hEE;
                @(negedge clk);
            end
            din_valid = 1'b1;
            din = p0 + 8'(i);
            @(negedge clk);
        end
        din_valid = 1'b0;
        din = 8'h00;
    endtask

    task automatic run_vec(input vec_t v, input int d);
        logic got;
        sel = d;
        @(negedge clk);
        len = v.len;
        dport = v.dport;
        ip_rdy = (v.rdy_delay == 0);
        if (d == 2) req2 = 1'b1; else req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        req2 = 1'b0;
        chk("ack",     32'(o_ack), 32'(!v.exp_err));
        chk("len_err", 32'(o_err), 32'(v.exp_err));
        chk("pkt_len", 32'(o_pl),  32'(v.exp_pkt_len));
        if (v.exp_err) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("rej_quiet", 32'({o_valid, o_ack, o_err, o_sreq}), 32'd0);
            end
            chk("rej_ready", 32'(o_rdy), 32'd1);
        end else begin
            chk("busy_ready", 32'(o_rdy), 32'd0);
            feed_payload(v.len, v.p0, 1'b1);
            got = 1'b0;
            if (v.rdy_delay > 0) begin
                for (int i = 0; i < 10 && !got; i++) begin
                    @(negedge clk);
                    got = o_sreq;
                end
                chk("sreq_timeout", 32'(got), 32'd1);
                for (int i = 0; i < v.rdy_delay; i++) begin
                    @(negedge clk);
                    chk("hold_sreq", 32'({o_sreq, o_valid}), 32'd2);
                end
                ip_rdy = 1'b1;
                @(negedge clk);
                chk("hdr_next_cycle", 32'(o_valid), 32'd1);
            end else begin
                for (int i = 0; i < 20 && !got; i++) begin
                    @(negedge clk);
                    got = o_valid;
                end
                chk("out_timeout", 32'(got), 32'd1);
            end
            for (int k = 0; k < int'(v.len) + 8; k++) begin
                chk("out_valid", 32'(o_valid), 32'd1);
                chk("out_byte",  32'(o_data),  32'(exp_byte(v, k)));
                @(negedge clk);
            end
            chk("end_valid", 32'(o_valid), 32'd0);
            chk("end_data",  32'(o_data),  32'd0);
            chk("end_ready", 32'(o_rdy),   32'd1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        n_vec = 0;
        n_err = 0;
        sel = 1;
        rstn = 1'b0; req1 = 1'b0; req2 = 1'b0; din_valid = 1'b0; din = 8'h00;
        ip_rdy = 1'b1; ip_ack = 1'b0; len = 16'h0000; dport = 16'h0000;
        sip = 32'hC0A8_010A;
        dip = 32'hC0A8_0164;

        vecs[0] = mk(16'd2,    16'h1F90, 8'h01, 0,  1'b0, 16'h000A, 16'h6B88);
        vecs[1] = mk(16'd0,    16'h1F90, 8'h01, 0,  1'b1, 16'h000A, 16'h0000);
        vecs[2] = mk(16'd2049, 16'h1F90, 8'h01, 0,  1'b1, 16'h000A, 16'h0000);
        vecs[3] = mk(16'd1,    16'h1F90, 8'hAB, 0,  1'b0, 16'h0009, 16'hC18B);
        vecs[4] = mk(16'd2,    16'h1F90, 8'h01, 20, 1'b0, 16'h000A, 16'h6B88);
        vecs[5] = mk(16'd4,    16'h0035, 8'h10, 3,  1'b0, 16'h000C, 16'h69BD);

        repeat (3) @(negedge clk);
        check_reset_state(1);
        check_reset_state(2);
        rstn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], 1);
        end

        // Reset while payload byte 3 of a 10-byte frame is on the output.
        sel = 1;
        @(negedge clk);
        len = 16'd10; dport = 16'h1F90; ip_rdy = 1'b1; req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        chk("mid_ack", 32'(o_ack), 32'd1);
        feed_payload(16'd10, 8'h30, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = o_valid;
        end
        chk("mid_out_timeout", 32'(got), 32'd1);
        repeat (10) @(negedge clk);
        chk("mid_byte3", 32'(o_data), 32'h32);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_valid",   32'(o_valid), 32'd0);
        chk("abort_data",    32'(o_data),  32'd0);
        chk("abort_ready",   32'(o_rdy),   32'd1);
        chk("abort_request", 32'(o_sreq),  32'd0);
        chk("abort_pkt_len", 32'(o_pl),    32'h0008);
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", 32'(o_valid), 32'd0);
        end
        run_vec(vecs[0], 1);

        // Checksum disabled, full buffer, then one byte too many.
        v2 = mk(16'd64, 16'h1234, 8'h00, 0, 1'b0, 16'h0048, 16'h0000);
        run_vec(v2, 2);
        v2 = mk(16'd65, 16'h1234, 8'h00, 0, 1'b1, 16'h0048, 16'h0000);
        run_vec(v2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
